// File: rtl/uart_rx_push_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_push_if : RX-FIFO write port (wr_en / din / full)            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_rx_push_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;

  modport master (output wr_en, output din, input full);
  modport slave  (input wr_en, input din, output full);
endinterface
`default_nettype wire

// File: rtl/uart_rx_push.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_push : 8N1 UART receiver pushing good bytes into the RX FIFO |
// | Optional even parity (8E1) when UART_RX_PARITY_EN is defined.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_push #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire logic      serial_in,
  uart_rx_push_if.master fifo,
  input  wire logic      clear_err,
  output logic           overrun,
  output logic           frame_err,
  output logic           busy
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int c_cnt_w = $clog2(SYMBOL_EDGE_TIME);
  localparam int c_idx_w = $clog2(DATA_WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(SYMBOL_EDGE_TIME / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(SYMBOL_EDGE_TIME - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_sync2;
  logic                  w_rx_s;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]    r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  w_tick;
  logic                  w_frame_bad;
  logic                  w_push, w_set_ovr, w_set_ferr;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_overrun, r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bad, w_par_bad_nxt;
`endif

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  assign w_frame_bad = r_par_bad;
`else
  assign w_frame_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_set_ovr   = 1'b0;
    w_set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = c_half_load;
        end
      end
      S_START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end else if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = c_full_load;
          w_idx_nxt   = '0;
`ifdef UART_RX_PARITY_EN
          w_par_bad_nxt = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end else begin
          w_shift_nxt = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
          w_cnt_nxt   = c_full_load;
          w_idx_nxt   = r_idx + c_idx_w'(1);
          if (r_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end else begin
          w_par_bad_nxt = (^r_shift) ^ w_rx_s;
          w_state_nxt   = S_STOP;
          w_cnt_nxt     = c_full_load;
        end
      end
`endif
      S_STOP: begin
        // Decision taken mid stop bit so back-to-back frames are caught.
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end else if (!w_rx_s) begin
          w_set_ferr  = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end else if (w_frame_bad) begin
          w_set_ferr  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (fifo.full) begin
          w_set_ovr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_din       <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en <= w_push;
      if (w_push) begin
        r_din <= r_shift;
      end
      if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_set_ferr) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign fifo.wr_en = r_wr_en;
  assign fifo.din   = r_din;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_push.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_push : directed frames against an event-based line model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_push;
  localparam int c_clk_freq = 1_000_000;
  localparam int c_baud     = 100_000;
  localparam int c_bit      = c_clk_freq / c_baud;
`ifdef UART_RX_PARITY_EN
  localparam int c_nbits     = 11;
  localparam int c_lat_lit   = 108;
  localparam int c_frame_lit = 110;
`else
  localparam int c_nbits     = 10;
  localparam int c_lat_lit   = 98;
  localparam int c_frame_lit = 100;
`endif
  // 2 sync flops + 1 detect clock, then half a bit to centre, then the rest of the frame
  localparam int c_stop_lat = 3 + c_bit / 2 + (c_nbits - 1) * c_bit;

  localparam int c_ev_busy_on  = 0;
  localparam int c_ev_busy_off = 1;
  localparam int c_ev_push     = 2;
  localparam int c_ev_ovr      = 3;
  localparam int c_ev_ferr     = 4;
  localparam int c_ev_clr      = 5;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic serial_in = 1'b1;
  logic clear_err = 1'b0;
  logic overrun, frame_err, busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  evq[$];
  logic [7:0] pushed[$];
  int   push_at[$];

  logic       m_busy = 1'b0;
  logic       m_wr   = 1'b0;
  logic [7:0] m_din  = 8'h00;
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_push_if #(.DATA_WIDTH(8)) fifo_if ();

  uart_rx_push #(
    .CLOCK_FREQ(c_clk_freq),
    .BAUD_RATE (c_baud),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .serial_in(serial_in),
    .fifo     (fifo_if),
    .clear_err(clear_err),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_ev(input int at, input int kind, input logic [7:0] data);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    e.data = data;
    evq.push_back(e);
  endtask

  task automatic model_step();
    m_wr = 1'b0;
    foreach (evq[i]) begin
      if (evq[i].at == cyc && evq[i].kind == c_ev_clr) begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
    end
    foreach (evq[i]) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          c_ev_busy_on:  m_busy = 1'b1;
          c_ev_busy_off: m_busy = 1'b0;
          c_ev_push: begin
            m_wr  = 1'b1;
            m_din = evq[i].data;
          end
          c_ev_ovr:  m_ovr  = 1'b1;
          c_ev_ferr: m_ferr = 1'b1;
          default: ;
        endcase
      end
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].at <= cyc) evq.delete(i);
    end
  endtask

  task automatic compare();
    chk("wr_en", {31'd0, fifo_if.wr_en}, {31'd0, m_wr});
    chk("din", {24'd0, fifo_if.din}, {24'd0, m_din});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (fifo_if.wr_en === 1'b1) begin
      pushed.push_back(fifo_if.din);
      push_at.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    compare();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int extra_low);
    int          p0;
    logic [10:0] bits;
    p0       = cyc;
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = ^d;
`endif
    bits[c_nbits-1] = stop_bit;
    add_ev(p0 + 3, c_ev_busy_on, 8'h00);
    if (!stop_bit) begin
      add_ev(p0 + c_stop_lat, c_ev_ferr, 8'h00);
    end else begin
      if (fifo_if.full) add_ev(p0 + c_stop_lat, c_ev_ovr, 8'h00);
      else              add_ev(p0 + c_stop_lat, c_ev_push, d);
      add_ev(p0 + c_stop_lat, c_ev_busy_off, 8'h00);
    end
    for (int i = 0; i < c_nbits; i++) begin
      serial_in = bits[i];
      repeat (c_bit) tick();
    end
    if (!stop_bit) begin
      repeat (extra_low) tick();
      serial_in = 1'b1;
      add_ev(cyc + 3, c_ev_busy_off, 8'h00);
    end
  endtask

  task automatic do_clear();
    add_ev(cyc + 1, c_ev_clr, 8'h00);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    int         start_a5;
    int         g;
    logic [7:0] part;
    fifo_if.full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_din", {24'd0, fifo_if.din}, 32'd0);
    chk("idle_flags", {30'd0, overrun, frame_err}, 32'd0);

    start_a5 = cyc;
    send_frame(8'hA5, 1'b1, 0);
    repeat (10) tick();
    chk("a5_count", pushed.size(), 32'd1);
    chk("a5_byte", {24'd0, pushed[0]}, 32'hA5);
    chk("a5_latency", push_at[0] - start_a5, c_lat_lit);

    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    repeat (10) tick();
    chk("b2b_count", pushed.size(), 32'd3);
    chk("b2b_first", {24'd0, pushed[1]}, 32'h00);
    chk("b2b_second", {24'd0, pushed[2]}, 32'hFF);
    chk("b2b_spacing", push_at[2] - push_at[1], c_frame_lit);

    fifo_if.full = 1'b1;
    send_frame(8'h3C, 1'b1, 0);
    repeat (5) tick();
    fifo_if.full = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_nopush", pushed.size(), 32'd3);
    do_clear();
    tick();
    chk("ovr_clear", {31'd0, overrun}, 32'd0);

    send_frame(8'h81, 1'b0, 30);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    chk("brk_ferr", {31'd0, frame_err}, 32'd1);
    chk("brk_nopush", pushed.size(), 32'd3);
    repeat (10) tick();
    chk("brk_idle", {31'd0, busy}, 32'd0);
    do_clear();
    tick();
    chk("ferr_clear", {31'd0, frame_err}, 32'd0);

    g = cyc;
    add_ev(g + 3, c_ev_busy_on, 8'h00);
    add_ev(g + 3 + c_bit / 2, c_ev_busy_off, 8'h00);
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    chk("glitch_nopush", pushed.size(), 32'd3);
    chk("glitch_flags", {30'd0, overrun, frame_err}, 32'd0);

    add_ev(cyc + 3, c_ev_busy_on, 8'h00);
    part = 8'h5A;
    serial_in = 1'b0;
    repeat (c_bit) tick();
    for (int i = 0; i < 3; i++) begin
      serial_in = part[i];
      repeat (c_bit) tick();
    end
    rst_n = 1'b0;
    evq.delete();
    m_busy = 1'b0;
    m_din  = 8'h00;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    serial_in = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_din", {24'd0, fifo_if.din}, 32'd0);
    chk("rst_wr", {31'd0, fifo_if.wr_en}, 32'd0);
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_nopush", pushed.size(), 32'd3);
    send_frame(8'h5A, 1'b1, 0);
    repeat (10) tick();
    chk("post_rst_count", pushed.size(), 32'd4);
    chk("post_rst_byte", {24'd0, pushed[3]}, 32'h5A);

    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
